// File: rtl/e603_irq_sched_pkg.sv
// Shared types and constants for the E603 subsystem interrupt scheduler.
// E603_IRQ_SCHED_RR_EN selects round-robin arbitration (fixed priority otherwise).
package e603_irq_sched_pkg;

  localparam int SRC_NUM = 9;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_EN   = 2'd0;
  localparam logic [1:0] SEL_MODE = 2'd1;
  localparam logic [1:0] SEL_PCLR = 2'd2;
  localparam logic [1:0] SEL_PEND = 2'd3;

  function automatic logic [SRC_NUM-1:0] id_onehot(input logic [ID_W-1:0] id);
    return SRC_NUM'(1) << id;
  endfunction

endpackage

// File: rtl/e603_irq_sched_arb.sv
// Combinational winner picker over the eligible (pending & enabled) vector.
// E603_IRQ_SCHED_RR_EN: round-robin from rr_ptr; otherwise lowest ID wins.
module e603_irq_sched_arb
  import e603_irq_sched_pkg::*;
(
`ifdef E603_IRQ_SCHED_RR_EN
  input  logic [ID_W-1:0]    rr_ptr,
`endif
  input  logic [SRC_NUM-1:0] eligible,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  assign any = |eligible;

`ifdef E603_IRQ_SCHED_RR_EN
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  // Walk SRC_NUM slots starting at rr_ptr, wrapping past SRC_NUM-1 back to 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(SRC_NUM)) sum = sum - (ID_W+1)'(SRC_NUM);
      idx = ID_W'(sum);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/e603_subsys_irq_sched.sv
// E603 subsystem interrupt scheduler: pending latch, one-in-flight offer/claim/complete.
// E603_IRQ_SCHED_RR_EN compiles in round-robin arbitration with rr_ptr.
module e603_subsys_irq_sched
  import e603_irq_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SRC_NUM-1:0] src_irq,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_sel,
  input  logic [SRC_NUM-1:0] cfg_wdata,
  output logic [SRC_NUM-1:0] cfg_rdata,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ready,
  input  logic               cmpl_valid,
  input  logic [ID_W-1:0]    cmpl_id,
  output logic               busy,
  output logic               cmpl_err,
  output logic [1:0]         state_dbg
);

  // Handshake: an offer (irq_valid, irq_id) is held stable until the cycle
  // irq_valid & irq_ready are both high; that cycle is the claim. irq_ready
  // outside an offer is ignored.

  logic [SRC_NUM-1:0] en, mode, pend, src_q;
  logic [SRC_NUM-1:0] rise, clr, pend_d;
  state_t             state, state_d;
  logic [ID_W-1:0]    cur_id, cur_id_d;
  logic               claim, arb_any;
  logic [ID_W-1:0]    arb_winner;

  assign rise  = src_irq & ~src_q;
  assign claim = (state == OFFER) && irq_ready;
  assign clr   = ((cfg_wr && (cfg_sel == SEL_PCLR)) ? cfg_wdata : '0) |
                 (claim ? id_onehot(cur_id) : '0);
  // Edge: a new rise wins over a same-cycle clear. Level: mirror the line.
  assign pend_d = (mode & (rise | (pend & ~clr))) | (~mode & src_irq);

`ifdef E603_IRQ_SCHED_RR_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (claim) begin
      rr_ptr <= (cur_id == ID_W'(SRC_NUM - 1)) ? '0 : cur_id + 1'b1;
    end
  end

  e603_irq_sched_arb u_arb (
    .rr_ptr   (rr_ptr),
    .eligible (pend & en),
    .any      (arb_any),
    .winner   (arb_winner)
  );
`else
  e603_irq_sched_arb u_arb (
    .eligible (pend & en),
    .any      (arb_any),
    .winner   (arb_winner)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= '0;
      mode     <= '0;
      pend     <= '0;
      src_q    <= '0;
      state    <= IDLE;
      cur_id   <= '0;
      cmpl_err <= 1'b0;
    end else begin
      src_q  <= src_irq;
      pend   <= pend_d;
      state  <= state_d;
      cur_id <= cur_id_d;
      if (cfg_wr && (cfg_sel == SEL_EN))   en   <= cfg_wdata;
      if (cfg_wr && (cfg_sel == SEL_MODE)) mode <= cfg_wdata;
      cmpl_err <= cmpl_valid && !((state == ACTIVE) && (cmpl_id == cur_id));
    end
  end

  always_comb begin
    state_d  = state;
    cur_id_d = cur_id;
    case (state)
      IDLE: begin
        if (arb_any) begin
          cur_id_d = arb_winner;
          state_d  = OFFER;
        end
      end
      OFFER:   if (irq_ready) state_d = ACTIVE;
      ACTIVE:  if (cmpl_valid && (cmpl_id == cur_id)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_sel)
      SEL_EN:   cfg_rdata = en;
      SEL_MODE: cfg_rdata = mode;
      SEL_PEND: cfg_rdata = pend;
      default:  cfg_rdata = '0;
    endcase
  end

  assign irq_valid = (state == OFFER);
  assign irq_id    = cur_id;
  assign busy      = (state == ACTIVE);
  assign state_dbg = state;

endmodule

// File: tb/tb_e603_subsys_irq_sched.sv
// Directed bench for e603_subsys_irq_sched: expected offer IDs queued at stimulus,
// popped and compared when the DUT raises irq_valid.
module tb_e603_subsys_irq_sched;
  import e603_irq_sched_pkg::*;

  logic               clk;
  logic               rst;
  logic [SRC_NUM-1:0] src_irq;
  logic               cfg_wr;
  logic [1:0]         cfg_sel;
  logic [SRC_NUM-1:0] cfg_wdata;
  logic [SRC_NUM-1:0] cfg_rdata;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ready;
  logic               cmpl_valid;
  logic [ID_W-1:0]    cmpl_id;
  logic               busy;
  logic               cmpl_err;
  logic [1:0]         state_dbg;

  logic [ID_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  e603_subsys_irq_sched dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .cfg_wr     (cfg_wr),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ready  (irq_ready),
    .cmpl_valid (cmpl_valid),
    .cmpl_id    (cmpl_id),
    .busy       (busy),
    .cmpl_err   (cmpl_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cfg_write(input logic [1:0] sel, input logic [SRC_NUM-1:0] data);
    cfg_wr    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    tick();
    cfg_wr    = 1'b0;
    cfg_sel   = SEL_PEND;
    cfg_wdata = '0;
  endtask

  task automatic pulse(input logic [SRC_NUM-1:0] v);
    src_irq = v;
    tick();
    src_irq = '0;
  endtask

  task automatic expect_offer(input int max_cyc, input string tag);
    logic [ID_W-1:0] e;
    for (int i = 0; i < max_cyc && !irq_valid; i++) tick();
    chk({tag, "_valid"}, 32'(irq_valid), 32'(1));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk({tag, "_id"}, 32'(irq_id), 32'(e));
  endtask

  task automatic claim_complete(input logic [ID_W-1:0] id, input string tag);
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    chk({tag, "_claim_busy"}, 32'(busy), 32'(1));
    chk({tag, "_claim_valid"}, 32'(irq_valid), 32'(0));
    cmpl_valid = 1'b1;
    cmpl_id    = id;
    tick();
    cmpl_valid = 1'b0;
    chk({tag, "_cmpl_busy"}, 32'(busy), 32'(0));
    chk({tag, "_cmpl_err"}, 32'(cmpl_err), 32'(0));
  endtask

  initial begin
    rst        = 1'b1;
    src_irq    = '0;
    cfg_wr     = 1'b0;
    cfg_sel    = SEL_PEND;
    cfg_wdata  = '0;
    irq_ready  = 1'b0;
    cmpl_valid = 1'b0;
    cmpl_id    = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_valid", 32'(irq_valid), 32'(0));
    chk("rst_id", 32'(irq_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(cmpl_err), 32'(0));
    chk("rst_pend", 32'(cfg_rdata), 32'(0));

    cfg_write(SEL_EN, 9'h1FF);
    cfg_write(SEL_MODE, 9'h1FF);
    cfg_sel = SEL_EN;
    #1 chk("rd_en", 32'(cfg_rdata), 32'h1FF);
    cfg_sel = SEL_PCLR;
    #1 chk("rd_pclr", 32'(cfg_rdata), 32'(0));
    cfg_sel = SEL_PEND;

    // single edge on src 5: pend at N+1, offer at N+2
    exp_q.push_back(4'd5);
    pulse(9'h020);
    chk("s5_pend", 32'(cfg_rdata), 32'h020);
    chk("s5_early_valid", 32'(irq_valid), 32'(0));
    tick();
    expect_offer(0, "s5");
    claim_complete(4'd5, "s5");
    chk("s5_pend_clr", 32'(cfg_rdata), 32'(0));
    tick();
    chk("s5_no_reoffer", 32'(irq_valid), 32'(0));

    // simultaneous edges on 2 and 7
`ifdef E603_IRQ_SCHED_RR_EN
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd2);
`else
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd7);
`endif
    pulse(9'h084);
    expect_offer(4, "pair_first");
    claim_complete(irq_id, "pair_first");
    chk("pair_gap", 32'(irq_valid), 32'(0));
    tick();
    expect_offer(0, "pair_second");
    claim_complete(irq_id, "pair_second");

    // level source 0: re-offered two cycles after completion, held through deassert
    cfg_write(SEL_MODE, 9'h1FE);
    exp_q.push_back(4'd0);
    src_irq = 9'h001;
    expect_offer(4, "lvl_a");
    claim_complete(4'd0, "lvl_a");
    exp_q.push_back(4'd0);
    tick();
    expect_offer(0, "lvl_b");
    src_irq = '0;
    cfg_write(SEL_EN, 9'h1FE);
    repeat (2) tick();
    chk("lvl_hold_valid", 32'(irq_valid), 32'(1));
    chk("lvl_hold_id", 32'(irq_id), 32'(0));
    claim_complete(4'd0, "lvl_b");
    cfg_write(SEL_EN, 9'h1FF);
    cfg_write(SEL_MODE, 9'h1FF);

    // wrong completion ID in ACTIVE, then correct one, then stray completion in IDLE
    exp_q.push_back(4'd3);
    pulse(9'h008);
    expect_offer(4, "s3");
    irq_ready = 1'b1;
    tick();
    irq_ready  = 1'b0;
    cmpl_valid = 1'b1;
    cmpl_id    = 4'd4;
    tick();
    cmpl_valid = 1'b0;
    chk("bad_id_err", 32'(cmpl_err), 32'(1));
    chk("bad_id_busy", 32'(busy), 32'(1));
    tick();
    chk("bad_id_err_pulse", 32'(cmpl_err), 32'(0));
    chk("bad_id_busy2", 32'(busy), 32'(1));
    cmpl_valid = 1'b1;
    cmpl_id    = 4'd3;
    tick();
    chk("good_id_busy", 32'(busy), 32'(0));
    chk("good_id_err", 32'(cmpl_err), 32'(0));
    tick();
    cmpl_valid = 1'b0;
    chk("idle_cmpl_err", 32'(cmpl_err), 32'(1));
    tick();
    chk("idle_cmpl_err_pulse", 32'(cmpl_err), 32'(0));

    // new edge and pending-clear on src 6 in the same cycle: set wins
    src_irq   = 9'h040;
    cfg_wr    = 1'b1;
    cfg_sel   = SEL_PCLR;
    cfg_wdata = 9'h040;
    tick();
    src_irq   = '0;
    cfg_wr    = 1'b0;
    cfg_sel   = SEL_PEND;
    cfg_wdata = '0;
    #1 chk("collide_pend", 32'(cfg_rdata), 32'h040);
    exp_q.push_back(4'd6);
    cfg_write(SEL_PCLR, 9'h040);
    chk("pclr_pend", 32'(cfg_rdata), 32'(0));
    expect_offer(0, "s6");
    claim_complete(4'd6, "s6");

    // reset while ACTIVE drops the in-flight interrupt
    exp_q.push_back(4'd1);
    pulse(9'h002);
    expect_offer(4, "s1");
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    chk("s1_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(irq_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    cfg_sel = SEL_EN;
    #1 chk("mid_rst_en", 32'(cfg_rdata), 32'(0));
    cfg_sel = SEL_MODE;
    #1 chk("mid_rst_mode", 32'(cfg_rdata), 32'(0));
    cfg_sel = SEL_PEND;
    #1 chk("mid_rst_pend", 32'(cfg_rdata), 32'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(irq_valid), 32'(0));

    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
